// File: rtl/scan_master_if.sv
// scan_master_if: host-side request/response bundle for scan_master.
//   req_valid/req_ready  request handshake (accepted when both high)
//   req_write            1 = load req_data into the chain, 0 = read-only
//   req_saddr            target buffer select
//   req_data             chain image, field k at [k*buffer_width +: buffer_width]
//   resp_valid           one-cycle completion pulse
//   resp_data            previous chain contents, same layout as req_data
//   busy                 transaction in flight
// Modports: master = host logic, slave = scan_master.
interface scan_master_if #(
    parameter int W = 176
);
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [2:0]   req_saddr;
    logic [W-1:0] req_data;
    logic         resp_valid;
    logic [W-1:0] resp_data;
    logic         busy;

    modport master (
        output req_valid, req_write, req_saddr, req_data,
        input  req_ready, resp_valid, resp_data, busy
    );

    modport slave (
        input  req_valid, req_write, req_saddr, req_data,
        output req_ready, resp_valid, resp_data, busy
    );
endinterface

// File: rtl/scan_master.sv
// scan_master: serial scan-chain master for the pattern buffer load/test port.
// Takes one whole buffer image per request, shifts it through the selected
// chain MSB first, and returns the bits that fell out (the old contents).
// In read-only mode the captured bits are fed straight back to sin, so the
// chain ends up unchanged.
// Ports:
//   i_clk, i_rst_n   system clock, synchronous active-low reset
//   io_host          request/response bundle (scan_master_if.slave)
//   o_sclk           scan clock, clk_div clk cycles per half-period
//   o_sin            scan data to the buffers
//   o_ssel           frame select, high from SETUP through HOLD
//   o_saddr          buffer address, latched at acceptance
//   i_sout           scan data from the buffers
module scan_master #(
    parameter int buffer_size  = 22,
    parameter int buffer_width = 8,
    parameter int clk_div      = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    scan_master_if.slave       io_host,
    output logic               o_sclk,
    output logic               o_sin,
    output logic               o_ssel,
    output logic [2:0]         o_saddr,
    input  logic               i_sout
);
    localparam int W     = buffer_size * buffer_width;
    localparam int CNT_W = $clog2(W + 1);
    localparam int DIV_W = $clog2(clk_div);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(clk_div - 1);
    // Capture edge: the one that starts the last cycle of SETUP/LOW.
    localparam logic [DIV_W-1:0] DIV_CAP  = DIV_W'(clk_div - 2);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(W);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_bit;
    logic [W-1:0]     r_tx;
    logic [W-1:0]     r_rx;
    logic [W-1:0]     r_resp;
    logic             r_write;
    logic             r_sin;
    logic [2:0]       r_saddr;
    logic             w_accept;
    logic             w_capture;
    logic             w_div_last;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_accept           = 1'b0;
        w_capture          = 1'b0;
        w_div_last         = (r_div == DIV_LAST);
        io_host.req_ready  = 1'b0;
        io_host.resp_valid = 1'b0;
        io_host.busy       = 1'b1;
        o_sclk             = 1'b0;
        o_ssel             = 1'b0;
        case (r_state)
            IDLE: begin
                io_host.busy      = 1'b0;
                io_host.req_ready = i_rst_n;
                if (io_host.req_valid && i_rst_n) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                o_ssel    = 1'b1;
                w_capture = (r_div == DIV_CAP);
                if (w_div_last) w_state_nxt = HIGH;
            end
            HIGH: begin
                o_ssel = 1'b1;
                o_sclk = 1'b1;
                if (w_div_last) w_state_nxt = (r_bit == BIT_LAST) ? HOLD : LOW;
            end
            LOW: begin
                o_ssel    = 1'b1;
                w_capture = (r_div == DIV_CAP);
                if (w_div_last) w_state_nxt = HIGH;
            end
            HOLD: begin
                o_ssel = 1'b1;
                if (w_div_last) w_state_nxt = DONE;
            end
            DONE: begin
                io_host.resp_valid = 1'b1;
                w_state_nxt        = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_resp  <= '0;
            r_write <= 1'b0;
            r_sin   <= 1'b0;
            r_saddr <= '0;
        end else begin
            // Divider restarts on every phase change.
            if (w_state_nxt != r_state) r_div <= '0;
            else                        r_div <= r_div + 1'b1;

            if (w_accept) begin
                r_write <= io_host.req_write;
                r_saddr <= io_host.req_saddr;
                r_tx    <= io_host.req_data;
                r_sin   <= io_host.req_write ? io_host.req_data[W-1] : 1'b0;
                r_bit   <= '0;
            end

            if (w_state_nxt == HIGH && r_state != HIGH) r_bit <= r_bit + 1'b1;

            // sout has been stable since the previous falling edge here.
            // Read-only mode recirculates it so the chain is restored.
            if (w_capture) begin
                r_rx <= {r_rx[W-2:0], i_sout};
                if (!r_write) r_sin <= i_sout;
            end

            if (r_write && r_state == HIGH && w_state_nxt == LOW) begin
                r_sin <= r_tx[W-2];
                r_tx  <= r_tx << 1;
            end

            if (w_state_nxt == DONE && r_state != DONE) r_resp <= r_rx;
        end
    end

    assign io_host.resp_data = r_resp;
    assign o_sin             = r_sin;
    assign o_saddr           = r_saddr;
endmodule

// File: tb/tb_scan_master.sv
module tb_scan_master;
    localparam int BS  = 2;
    localparam int BWD = 8;
    localparam int CD  = 2;
    localparam int W   = BS * BWD;
    localparam int LAT = CD * (2 * W + 1) + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk, sin, ssel, sout;
    logic [2:0] saddr;

    always #5 clk = ~clk;

    scan_master_if #(.W(W)) hif();

    scan_master #(.buffer_size(BS), .buffer_width(BWD), .clk_div(CD)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_host (hif),
        .o_sclk  (sclk),
        .o_sin   (sin),
        .o_ssel  (ssel),
        .o_saddr (saddr),
        .i_sout  (sout)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Pattern buffer chains: plain shift registers clocked by sclk rises.
    logic [W-1:0] chains  [8];
    logic [W-1:0] ref_mem [8];
    logic         ld_en = 1'b0;
    logic         clr = 1'b0;
    logic [2:0]   ld_addr = '0;
    logic [W-1:0] ld_val = '0;
    logic         sclk_q = 1'b0, sin_q = 1'b0, ssel_q = 1'b0;
    logic [2:0]   saddr_q = '0;
    int           rises = 0, frames = 0, viol = 0;
    logic [W-1:0] sin_vec = '0, sout_vec = '0;

    assign sout = chains[saddr][W-1];

    always @(posedge clk) begin
        if (ld_en)
            chains[ld_addr] <= ld_val;
        else if (sclk && !sclk_q && ssel)
            chains[saddr] <= {chains[saddr][W-2:0], sin};
        if (clr) begin
            rises    <= 0;
            sin_vec  <= '0;
            sout_vec <= '0;
        end else if (sclk && !sclk_q) begin
            rises    <= rises + 1;
            sin_vec  <= {sin_vec[W-2:0], sin};
            sout_vec <= {sout_vec[W-2:0], sout};
        end
        viol <= viol + int'(sclk && !ssel)
                     + int'(sclk && sclk_q && (sin !== sin_q || saddr !== saddr_q));
        if (ssel && !ssel_q) frames <= frames + 1;
        sclk_q  <= sclk;
        sin_q   <= sin;
        saddr_q <= saddr;
        ssel_q  <= ssel;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ld(input logic [2:0] a, input logic [W-1:0] v);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_val  = v;
        ref_mem[a] = v;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic clear_log();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    // Issue one request and wait for acceptance; inputs are scrambled after.
    task automatic issue(input bit wr, input logic [2:0] a, input logic [W-1:0] d, input bit hold);
        int n;
        hif.req_valid = 1'b1;
        hif.req_write = wr;
        hif.req_saddr = a;
        hif.req_data  = d;
        n = 0;
        while (!hif.req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!hif.req_ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        hif.req_valid = hold;
        hif.req_data  = ~d;
        hif.req_saddr = a + 3'd1;
        hif.req_write = ~wr;
    endtask

    // Returns cycles from the acceptance cycle to resp_valid.
    task automatic wait_resp(output logic [W-1:0] rsp, output int lat);
        lat = 1;
        while (!hif.resp_valid && lat < LAT + 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!hif.resp_valid) chk("resp_timeout", 0, 1);
        rsp = hif.resp_data;
    endtask

    task automatic run(input bit wr, input logic [2:0] a, input logic [W-1:0] d,
                       output logic [W-1:0] rsp, output int lat);
        clear_log();
        issue(wr, a, d, 1'b0);
        wait_resp(rsp, lat);
    endtask

    initial begin
        logic [W-1:0] rsp, rsp2, exp, d, r;
        logic [2:0]   a;
        bit           wr;
        int           lat, f0, n, seen;

        hif.req_valid = 1'b0;
        hif.req_write = 1'b0;
        hif.req_saddr = '0;
        hif.req_data  = '0;

        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_out", {sclk, sin, ssel, saddr, hif.resp_valid, hif.busy, hif.req_ready}, 0);
            chk("rst_resp", hif.resp_data, 0);
        end
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", hif.req_ready, 1);

        for (int i = 0; i < 8; i++) ld(3'(i), W'($urandom));
        ld(3'd3, 16'h1234);

        // Write then read back.
        run(1'b1, 3'd3, 16'hA55A, rsp, lat);
        chk("wr_resp", rsp, 16'h1234);
        chk("wr_lat", lat, LAT);
        chk("wr_busy", hif.busy, 1);
        chk("wr_rises", rises, W);
        chk("wr_chain", chains[3], 16'hA55A);
        @(posedge clk); #1;
        chk("rv_pulse", hif.resp_valid, 0);
        ref_mem[3] = 16'hA55A;

        run(1'b0, 3'd3, 16'h0F0F, rsp, lat);
        chk("rd_resp", rsp, 16'hA55A);
        chk("rd_chain", chains[3], 16'hA55A);
        chk("rd_rises", rises, W);
        chk("rd_sin_seq", sin_vec, sout_vec);
        chk("rd_sout_seq", sout_vec, 16'hA55A);

        // Back-to-back with req_valid held high.
        r = W'($urandom);
        ld(3'd1, r);
        @(posedge clk); #1;
        f0 = frames;
        issue(1'b1, 3'd1, 16'hFFFF, 1'b1);
        hif.req_data  = 16'h0000;
        hif.req_write = 1'b1;
        hif.req_saddr = 3'd1;
        wait_resp(rsp, lat);
        chk("bb_resp1", rsp, r);
        chk("bb_lat1", lat, LAT);
        @(posedge clk); #1;
        chk("bb_ready", hif.req_ready, 1);
        @(posedge clk); #1;
        hif.req_valid = 1'b0;
        wait_resp(rsp2, lat);
        chk("bb_resp2", rsp2, 16'hFFFF);
        chk("bb_chain", chains[1], 16'h0000);
        @(posedge clk); #1;
        chk("bb_frames", frames - f0, 2);
        ref_mem[1] = '0;

        // Reset in the middle of a frame.
        ld(3'd5, W'($urandom));
        clear_log();
        issue(1'b1, 3'd5, W'($urandom), 1'b0);
        n = 0;
        while (rises < 5 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mr_reach5", rises, 5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mr_ssel", ssel, 0);
        chk("mr_busy", hif.busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (LAT + 10) begin
            @(posedge clk); #1;
            seen += int'(hif.resp_valid);
        end
        chk("mr_no_resp", seen, 0);
        d = W'($urandom);
        ld(3'd5, d);
        run(1'b1, 3'd5, 16'h5AA5, rsp, lat);
        chk("mr_after_resp", rsp, d);
        chk("mr_after_lat", lat, LAT);
        chk("mr_after_chain", chains[5], 16'h5AA5);
        ref_mem[5] = 16'h5AA5;

        // Randomized traffic against the memory reference.
        for (int i = 0; i < 10; i++) begin
            a   = 3'($urandom_range(0, 7));
            wr  = 1'($urandom_range(0, 1));
            d   = W'($urandom);
            exp = ref_mem[a];
            run(wr, a, d, rsp, lat);
            if (wr) ref_mem[a] = d;
            chk("rnd_resp", rsp, exp);
            chk("rnd_lat", lat, LAT);
            chk("rnd_chain", chains[a], ref_mem[a]);
        end

        chk("protocol", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/scan_master.md
Name: scan_master

Overview:
- Serial scan-chain master that drives the pattern buffer test/load port (sclk, sin, ssel, saddr) and captures sout.
- The host side issues a parallel request for one whole buffer image. The block exchanges it over the chain and returns the previous contents.
- Sits between the configuration/host logic and the pattern buffer scan port. Allows buffers to be loaded and read back without the pat processor.

Parameters:
- buffer_size, 22, number of fields per buffer
- buffer_width, 8, bits per field
- clk_div, 4, clk cycles per sclk half-period; legal values are 2 or more
- W (localparam), buffer_size*buffer_width, chain length in bits

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (IDLE only)
- req_write  in  1  1 = shift req_data in; 0 = read-only (recirculate old contents)
- req_saddr  in  3  target buffer select
- req_data  in  W  image to load; bits [k*buffer_width +: buffer_width] = field k
- resp_valid  out  1  one-cycle pulse: transaction complete
- resp_data  out  W  previous chain contents, same layout as req_data
- busy  out  1  high from acceptance through the resp_valid cycle
- sclk  out  1  scan clock
- sin  out  1  scan data to buffers
- ssel  out  1  scan select, frames the transaction
- saddr  out  3  scan buffer address
- sout  in  1  scan data from buffers

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - sclk, sin, ssel, saddr, resp_valid, resp_data, busy are all driven to 0.
  - req_ready is 0 while rst_n is low.
  - State goes to IDLE.
  - Reset mid-frame aborts the transaction: ssel=0 the next cycle and no resp_valid is generated.
- Handshake:
  - A request is accepted on a cycle with req_valid && req_ready.
  - req_saddr, req_write and req_data are latched on acceptance; later changes are ignored.
  - req_ready=1 only in IDLE.
- Bit order:
  - Chain word = req_data; bit W-1 is shifted first, bit 0 last.
  - The first sout bit captured is old bit W-1.
- FSM states: IDLE, SETUP, HIGH, LOW, HOLD, DONE.
  - IDLE: ssel=0, sclk=0. Accept moves to SETUP.
  - SETUP: ssel=1, saddr=latched address, sclk=0, sin=first bit. Lasts clk_div cycles, then HIGH.
  - HIGH: sclk=1 for clk_div cycles. The buffers sample sin on the rising edge. Bit counter increments on entry. After the W-th HIGH, go to HOLD; otherwise go to LOW.
  - LOW: sclk=0 for clk_div cycles. On entry, write mode drives the next req bit on sin.
  - HOLD: sclk=0, ssel=1 for clk_div cycles, then DONE.
  - DONE: ssel=0, resp_valid=1 for exactly one cycle, then IDLE.
- sout capture:
  - sout is sampled on the clk edge that begins the last cycle of each SETUP/LOW phase. This is one clk before sclk rises, so the bit is stable from the previous falling edge.
  - The captured bit is shifted into the rx register, MSB first.
- Read-only mode:
  - sin is updated with the just-captured sout bit at that same edge, one clk before the rising edge.
  - Chain contents are therefore restored unchanged.
  - In write mode sin is set on LOW/SETUP entry and is stable at least clk_div-1 cycles before each rising edge.
- Hold rules: sin and saddr are stable throughout every HIGH phase. saddr holds its value until after ssel falls.
- resp_data:
  - Loaded from the rx register on entry to DONE.
  - Held until the next DONE or reset.
- Latency: resp_valid is asserted clk_div*(2W+1)+1 cycles after the acceptance cycle. The frame has exactly W rising sclk edges.
- Counters: bit counter is ceil(log2(W+1)) bits; divider is ceil(log2(clk_div)) bits. No wrap beyond W.
- Back-to-back requests: req_valid held high in the DONE cycle is accepted on the following IDLE cycle. Between frames ssel is low for at least 1 cycle.

Test Plan:
- Reset: rst_n=0 for 3 cycles, then release -> all outputs 0 during reset; req_ready=1 the first cycle after release.
- Write then read-back, with buffer_size=2, width=8, clk_div=2 (W=16): write 0xA55A to saddr=3 against a chain model holding 0x1234.
  - Exactly 16 rising sclk edges.
  - resp_valid 67 cycles after accept.
  - resp_data=0x1234; model holds 0xA55A.
- Read-only: req_write=0 on a model holding 0xA55A -> resp_data=0xA55A; model still 0xA55A; sin bit sequence equals the sout bit sequence.
- Protocol timing: monitor checks that sin and saddr never change while sclk=1, ssel is high across all 16 edges, and sclk=0 whenever ssel=0.
- Mid-frame reset: assert rst_n=0 after the 5th rising edge -> ssel=0 the next cycle, no resp_valid; a subsequent full request completes normally.
- Back-to-back requests with req_valid held high: two requests with data 0xFFFF then 0x0000 -> second resp_data=0xFFFF; ssel low ≥1 cycle between frames; req_data changes after accept are ignored.
